// File: rtl/nano_lockstep_checker_if.sv
// Per-channel DUT/reference event streams feeding nano_lockstep_checker.
// i_cmp_mask exists only when NANO_LOCKSTEP_MASK_EN is defined.
interface nano_lockstep_checker_if #(
  parameter int unsigned CH_C   = 4,
  parameter int unsigned CH_W_C = 16
);
  logic [CH_C-1:0]        i_dut_valid;
  logic [CH_C*CH_W_C-1:0] i_dut_data;
  logic [CH_C-1:0]        i_ref_valid;
  logic [CH_C*CH_W_C-1:0] i_ref_data;
`ifdef NANO_LOCKSTEP_MASK_EN
  logic [CH_C*CH_W_C-1:0] i_cmp_mask;

  modport master (output i_dut_valid, i_dut_data, i_ref_valid, i_ref_data, i_cmp_mask);
  modport slave  (input  i_dut_valid, i_dut_data, i_ref_valid, i_ref_data, i_cmp_mask);
`else
  modport master (output i_dut_valid, i_dut_data, i_ref_valid, i_ref_data);
  modport slave  (input  i_dut_valid, i_dut_data, i_ref_valid, i_ref_data);
`endif
endinterface

// File: rtl/nano_lockstep_checker.sv
// Multi-channel lockstep comparator: per-side skew FIFOs realign DUT/reference streams,
// count mismatches and capture the first failing event. Optional mask: NANO_LOCKSTEP_MASK_EN.
module nano_lockstep_checker #(
  parameter int unsigned CH_C          = 4,
  parameter int unsigned CH_W_C        = 16,
  parameter int unsigned SKEW_DEPTH_C  = 4,
  parameter int unsigned ERR_CNT_W_C   = 8,
  parameter int unsigned STOP_ON_ERR_C = 0
) (
  input  logic                          i_nano_clk,
  input  logic                          i_nano_rst_n,
  input  logic                          i_enable,
  input  logic                          i_clear,
  nano_lockstep_checker_if.slave        bus,
  output logic [CH_C-1:0]               o_mismatch,
  output logic [CH_C*ERR_CNT_W_C-1:0]   o_err_cnt,
  output logic [CH_C-1:0]               o_overflow,
  output logic                          o_first_valid,
  output logic [$clog2(CH_C)-1:0]       o_first_ch,
  output logic [CH_W_C-1:0]             o_first_dut,
  output logic [CH_W_C-1:0]             o_first_ref,
  output logic                          o_halted
);

  localparam int unsigned PTR_W = $clog2(SKEW_DEPTH_C);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned IDX_W = $clog2(CH_C);

  typedef logic [CH_W_C-1:0] word_t;
  typedef enum logic {ST_ARMED = 1'b0, ST_HALTED = 1'b1} state_e;

  state_e                 state_q, state_d;
  word_t                  mem_q [CH_C][2][SKEW_DEPTH_C];
  word_t                  mem_d [CH_C][2][SKEW_DEPTH_C];
  logic [PTR_W-1:0]       wr_q [CH_C][2];
  logic [PTR_W-1:0]       wr_d [CH_C][2];
  logic [PTR_W-1:0]       rd_q [CH_C][2];
  logic [PTR_W-1:0]       rd_d [CH_C][2];
  logic [CNT_W-1:0]       cnt_q [CH_C][2];
  logic [CNT_W-1:0]       cnt_d [CH_C][2];
  logic [CH_C-1:0]        mismatch_q, mismatch_d;
  logic [CH_C-1:0]        overflow_q, overflow_d;
  logic [ERR_CNT_W_C-1:0] err_cnt_q [CH_C];
  logic [ERR_CNT_W_C-1:0] err_cnt_d [CH_C];
  logic                   first_valid_q, first_valid_d;
  logic [IDX_W-1:0]       first_ch_q, first_ch_d;
  word_t                  first_dut_q, first_dut_d;
  word_t                  first_ref_q, first_ref_d;

  logic                   armed_c;
  logic                   any_mis_c;
  logic                   cap_c;
  logic [1:0]             in_valid_c [CH_C];
  logic [1:0]             nonempty_c [CH_C];
  logic [1:0]             push_c [CH_C];
  logic [1:0]             pop_c [CH_C];
  logic [1:0]             wr_c [CH_C];
  logic [1:0]             full_c [CH_C];
  word_t                  in_data_c [CH_C][2];
  word_t                  head_c [CH_C][2];
  word_t                  mask_c [CH_C];
  logic [CH_C-1:0]        cmp_c, mis_c;

  assign armed_c = (state_q == ST_ARMED);

  // Global FSM: a mismatch halts only when stop-on-error is configured.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARMED:  if (!i_clear && (STOP_ON_ERR_C != 0) && any_mis_c) state_d = ST_HALTED;
      ST_HALTED: if (i_clear) state_d = ST_ARMED;
      default:   state_d = ST_ARMED;
    endcase
  end

  // Skew FIFOs, compare, counters and first-error capture. Side 0 = DUT, side 1 = reference.
  always_comb begin
    mem_d         = mem_q;
    wr_d          = wr_q;
    rd_d          = rd_q;
    cnt_d         = cnt_q;
    mismatch_d    = '0;
    overflow_d    = overflow_q;
    err_cnt_d     = err_cnt_q;
    first_valid_d = first_valid_q;
    first_ch_d    = first_ch_q;
    first_dut_d   = first_dut_q;
    first_ref_d   = first_ref_q;
    cap_c         = 1'b0;
    in_valid_c    = '{default: '0};
    nonempty_c    = '{default: '0};
    push_c        = '{default: '0};
    pop_c         = '{default: '0};
    wr_c          = '{default: '0};
    full_c        = '{default: '0};
    in_data_c     = '{default: '0};
    head_c        = '{default: '0};
    mask_c        = '{default: '0};
    cmp_c         = '0;
    mis_c         = '0;

    for (int k = 0; k < CH_C; k++) begin
      in_valid_c[k][0] = bus.i_dut_valid[k];
      in_valid_c[k][1] = bus.i_ref_valid[k];
      in_data_c[k][0]  = bus.i_dut_data[k*CH_W_C +: CH_W_C];
      in_data_c[k][1]  = bus.i_ref_data[k*CH_W_C +: CH_W_C];
`ifdef NANO_LOCKSTEP_MASK_EN
      mask_c[k]        = bus.i_cmp_mask[k*CH_W_C +: CH_W_C];
`endif
      // An empty FIFO exposes the same-cycle input as its head (bypass).
      for (int s = 0; s < 2; s++) begin
        nonempty_c[k][s] = (cnt_q[k][s] != '0);
        full_c[k][s]     = (cnt_q[k][s] == CNT_W'(SKEW_DEPTH_C));
        push_c[k][s]     = in_valid_c[k][s] & i_enable & armed_c & ~i_clear;
        head_c[k][s]     = nonempty_c[k][s] ? mem_q[k][s][rd_q[k][s]] : in_data_c[k][s];
      end

      cmp_c[k] = armed_c & ~i_clear & (nonempty_c[k][0] | push_c[k][0])
                                    & (nonempty_c[k][1] | push_c[k][1]);
      mis_c[k] = cmp_c[k] & (((head_c[k][0] ^ head_c[k][1]) & ~mask_c[k]) != '0);

      for (int s = 0; s < 2; s++) begin
        pop_c[k][s] = cmp_c[k] & nonempty_c[k][s];
        wr_c[k][s]  = push_c[k][s] & ~(cmp_c[k] & ~nonempty_c[k][s]);
        if (wr_c[k][s] && (!full_c[k][s] || pop_c[k][s])) begin
          mem_d[k][s][wr_q[k][s]] = in_data_c[k][s];
          wr_d[k][s]  = wr_q[k][s] + PTR_W'(1);
          cnt_d[k][s] = cnt_q[k][s] + CNT_W'(1);
        end else if (wr_c[k][s]) begin
          overflow_d[k] = 1'b1;
        end
        if (pop_c[k][s]) begin
          rd_d[k][s]  = rd_q[k][s] + PTR_W'(1);
          cnt_d[k][s] = cnt_d[k][s] - CNT_W'(1);
        end
      end

      mismatch_d[k] = mis_c[k];
      if (mis_c[k] && (err_cnt_q[k] != '1)) err_cnt_d[k] = err_cnt_q[k] + ERR_CNT_W_C'(1);

      // Ascending scan: lowest failing channel wins the capture.
      if (mis_c[k] && !first_valid_q && !cap_c) begin
        cap_c         = 1'b1;
        first_valid_d = 1'b1;
        first_ch_d    = IDX_W'(k);
        first_dut_d   = head_c[k][0];
        first_ref_d   = head_c[k][1];
      end
    end

    if (i_clear) begin
      wr_d          = '{default: '0};
      rd_d          = '{default: '0};
      cnt_d         = '{default: '0};
      mismatch_d    = '0;
      overflow_d    = '0;
      err_cnt_d     = '{default: '0};
      first_valid_d = 1'b0;
      first_ch_d    = '0;
      first_dut_d   = '0;
      first_ref_d   = '0;
    end
  end

  assign any_mis_c = |mis_c;

  always_ff @(posedge i_nano_clk or negedge i_nano_rst_n) begin
    if (!i_nano_rst_n) begin
      state_q       <= ST_ARMED;
      mem_q         <= '{default: '0};
      wr_q          <= '{default: '0};
      rd_q          <= '{default: '0};
      cnt_q         <= '{default: '0};
      mismatch_q    <= '0;
      overflow_q    <= '0;
      err_cnt_q     <= '{default: '0};
      first_valid_q <= 1'b0;
      first_ch_q    <= '0;
      first_dut_q   <= '0;
      first_ref_q   <= '0;
    end else begin
      state_q       <= state_d;
      mem_q         <= mem_d;
      wr_q          <= wr_d;
      rd_q          <= rd_d;
      cnt_q         <= cnt_d;
      mismatch_q    <= mismatch_d;
      overflow_q    <= overflow_d;
      err_cnt_q     <= err_cnt_d;
      first_valid_q <= first_valid_d;
      first_ch_q    <= first_ch_d;
      first_dut_q   <= first_dut_d;
      first_ref_q   <= first_ref_d;
    end
  end

  always_comb begin
    o_err_cnt = '0;
    for (int k = 0; k < CH_C; k++) o_err_cnt[k*ERR_CNT_W_C +: ERR_CNT_W_C] = err_cnt_q[k];
  end

  assign o_mismatch    = mismatch_q;
  assign o_overflow    = overflow_q;
  assign o_first_valid = first_valid_q;
  assign o_first_ch    = first_ch_q;
  assign o_first_dut   = first_dut_q;
  assign o_first_ref   = first_ref_q;
  assign o_halted      = (state_q == ST_HALTED);

endmodule

// File: tb/tb_nano_lockstep_checker.sv
// Directed bench for nano_lockstep_checker: vector table on the default instance plus
// hand sequences for saturation, halt, clear and async reset on 2-bit-counter instances.
module tb_nano_lockstep_checker;
  localparam int unsigned CH = 4;
  localparam int unsigned W  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  nano_lockstep_checker_if #(.CH_C(CH), .CH_W_C(W)) bus ();

  logic [3:0]  m_mis, m_ovf, s_mis, s_ovf, h_mis, h_ovf;
  logic [31:0] m_cnt;
  logic [7:0]  s_cnt, h_cnt;
  logic        m_fv, m_halt, s_fv, s_halt, h_fv, h_halt;
  logic [1:0]  m_fch, s_fch, h_fch;
  logic [15:0] m_fdut, m_fref, s_fdut, s_fref, h_fdut, h_fref;

  nano_lockstep_checker u_main (
    .i_nano_clk(clk), .i_nano_rst_n(rst_n), .i_enable(en), .i_clear(clr), .bus(bus),
    .o_mismatch(m_mis), .o_err_cnt(m_cnt), .o_overflow(m_ovf), .o_first_valid(m_fv),
    .o_first_ch(m_fch), .o_first_dut(m_fdut), .o_first_ref(m_fref), .o_halted(m_halt));

  nano_lockstep_checker #(.ERR_CNT_W_C(2), .STOP_ON_ERR_C(0)) u_sat (
    .i_nano_clk(clk), .i_nano_rst_n(rst_n), .i_enable(en), .i_clear(clr), .bus(bus),
    .o_mismatch(s_mis), .o_err_cnt(s_cnt), .o_overflow(s_ovf), .o_first_valid(s_fv),
    .o_first_ch(s_fch), .o_first_dut(s_fdut), .o_first_ref(s_fref), .o_halted(s_halt));

  nano_lockstep_checker #(.ERR_CNT_W_C(2), .STOP_ON_ERR_C(1)) u_halt (
    .i_nano_clk(clk), .i_nano_rst_n(rst_n), .i_enable(en), .i_clear(clr), .bus(bus),
    .o_mismatch(h_mis), .o_err_cnt(h_cnt), .o_overflow(h_ovf), .o_first_valid(h_fv),
    .o_first_ch(h_fch), .o_first_dut(h_fdut), .o_first_ref(h_fref), .o_halted(h_halt));

  typedef struct {
    logic [3:0]  dv, rv;
    logic [63:0] dd, rd;
    logic        en, clr;
    logic [3:0]  mis, ovf;
    logic [31:0] cnt;
    logic        fv;
    logic [1:0]  fch;
    logic [15:0] fdut, fref;
  } vec_t;

  vec_t vecs[$];
  logic [3:0]  e_mis = '0, e_ovf = '0;
  logic [31:0] e_cnt = '0;
  logic        e_fv = 1'b0;
  logic [1:0]  e_fch = '0;
  logic [15:0] e_fdut = '0, e_fref = '0;
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [63:0] pk(input int ch, input logic [15:0] v);
    logic [63:0] r;
    r = '0;
    r[ch*16 +: 16] = v;
    return r;
  endfunction

  function automatic void add(input logic [3:0] dv, input logic [63:0] dd, input logic [3:0] rv,
                              input logic [63:0] rd, input logic en_i, input logic clr_i);
    vec_t v;
    v.dv = dv; v.dd = dd; v.rv = rv; v.rd = rd; v.en = en_i; v.clr = clr_i;
    v.mis = e_mis; v.ovf = e_ovf; v.cnt = e_cnt;
    v.fv = e_fv; v.fch = e_fch; v.fdut = e_fdut; v.fref = e_fref;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] dv, input logic [63:0] dd, input logic [3:0] rv,
                       input logic [63:0] rd, input logic en_i, input logic clr_i);
    bus.i_dut_valid = dv; bus.i_dut_data = dd;
    bus.i_ref_valid = rv; bus.i_ref_data = rd;
    en = en_i; clr = clr_i;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef NANO_LOCKSTEP_MASK_EN
    bus.i_cmp_mask = '0;
`endif
    drive(4'b0, 64'b0, 4'b0, 64'b0, 1'b0, 1'b0);

    // Lockstep, channel 0
    for (int i = 0; i < 10; i++) add(4'b0001, pk(0, 16'h0123), 4'b0001, pk(0, 16'h0123), 1'b1, 1'b0);
    // Skew on channel 1: DUT leads by three events
    add(4'b0010, pk(1, 16'h000A), 4'b0, 64'b0, 1'b1, 1'b0);
    add(4'b0010, pk(1, 16'h000B), 4'b0, 64'b0, 1'b1, 1'b0);
    add(4'b0010, pk(1, 16'h000C), 4'b0, 64'b0, 1'b1, 1'b0);
    add(4'b0, 64'b0, 4'b0010, pk(1, 16'h000A), 1'b1, 1'b0);
    add(4'b0, 64'b0, 4'b0010, pk(1, 16'h000B), 1'b1, 1'b0);
    add(4'b0, 64'b0, 4'b0010, pk(1, 16'h000C), 1'b1, 1'b0);
    add(4'b0010, pk(1, 16'h000D), 4'b0010, pk(1, 16'h000D), 1'b1, 1'b0);
    // Overflow on channel 2, then push into a full FIFO that is popped the same cycle
    for (int i = 0; i < 4; i++) add(4'b0100, pk(2, 16'h0021 + 16'(i)), 4'b0, 64'b0, 1'b1, 1'b0);
    e_ovf = 4'b0100;
    add(4'b0100, pk(2, 16'h0025), 4'b0, 64'b0, 1'b1, 1'b0);
    add(4'b0100, pk(2, 16'h0026), 4'b0100, pk(2, 16'h0021), 1'b1, 1'b0);
    add(4'b0, 64'b0, 4'b0100, pk(2, 16'h0022), 1'b1, 1'b0);
    add(4'b0, 64'b0, 4'b0100, pk(2, 16'h0023), 1'b1, 1'b0);
    add(4'b0, 64'b0, 4'b0100, pk(2, 16'h0024), 1'b1, 1'b0);
    add(4'b0, 64'b0, 4'b0100, pk(2, 16'h0026), 1'b1, 1'b0);
    add(4'b0100, pk(2, 16'h0030), 4'b0100, pk(2, 16'h0030), 1'b1, 1'b0);
    // Simultaneous mismatches on ch3 and ch1: ch1 captured
    e_mis = 4'b1010; e_cnt = 32'h0100_0100;
    e_fv = 1'b1; e_fch = 2'd1; e_fdut = 16'h0001; e_fref = 16'h0002;
    add(4'b1010, pk(3, 16'h00FF) | pk(1, 16'h0001), 4'b1010, pk(3, 16'h00FE) | pk(1, 16'h0002), 1'b1, 1'b0);
    e_mis = 4'b0;
    add(4'b0, 64'b0, 4'b0, 64'b0, 1'b1, 1'b0);
    e_mis = 4'b0001; e_cnt = 32'h0100_0101;
    add(4'b0001, pk(0, 16'h0005), 4'b0001, pk(0, 16'h0006), 1'b1, 1'b0);
    // Enable low ignores valids
    e_mis = 4'b0;
    add(4'b0001, pk(0, 16'h0099), 4'b0, 64'b0, 1'b0, 1'b0);
    add(4'b0001, pk(0, 16'h0040), 4'b0001, pk(0, 16'h0040), 1'b1, 1'b0);
    add(4'b0001, pk(0, 16'h0001), 4'b0001, pk(0, 16'h0002), 1'b0, 1'b0);
    // Clear beats same-cycle events and flushes queued ones
    add(4'b1000, pk(3, 16'h0011), 4'b0, 64'b0, 1'b1, 1'b0);
    e_ovf = '0; e_cnt = '0; e_fv = 1'b0; e_fch = '0; e_fdut = '0; e_fref = '0;
    add(4'b1001, pk(0, 16'h0007) | pk(3, 16'h0012), 4'b0001, pk(0, 16'h0008), 1'b1, 1'b1);
    add(4'b1000, pk(3, 16'h0077), 4'b1000, pk(3, 16'h0077), 1'b1, 1'b0);
    // Skewed mismatch reported one cycle after the later event
    add(4'b0010, pk(1, 16'h000A), 4'b0, 64'b0, 1'b1, 1'b0);
    add(4'b0, 64'b0, 4'b0, 64'b0, 1'b1, 1'b0);
    e_mis = 4'b0010; e_cnt = 32'h0000_0100;
    e_fv = 1'b1; e_fch = 2'd1; e_fdut = 16'h000A; e_fref = 16'h000B;
    add(4'b0, 64'b0, 4'b0010, pk(1, 16'h000B), 1'b1, 1'b0);

    #1 rst_n = 1'b0;
    tick();
    chk("reset main a", 64'({m_mis, m_cnt, m_ovf}), 64'd0);
    chk("reset main b", 64'({m_fv, m_fch, m_fdut, m_fref, m_halt}), 64'd0);
    chk("reset halt inst", 64'({h_halt, h_cnt, h_fv}), 64'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].dv, vecs[i].dd, vecs[i].rv, vecs[i].rd, vecs[i].en, vecs[i].clr);
      tick();
      chk($sformatf("v%0d mismatch", i), 64'(m_mis), 64'(vecs[i].mis));
      chk($sformatf("v%0d overflow", i), 64'(m_ovf), 64'(vecs[i].ovf));
      chk($sformatf("v%0d err_cnt", i), 64'(m_cnt), 64'(vecs[i].cnt));
      chk($sformatf("v%0d first", i), 64'({m_fv, m_fch, m_fdut, m_fref}),
          64'({vecs[i].fv, vecs[i].fch, vecs[i].fdut, vecs[i].fref}));
      chk($sformatf("v%0d halted", i), 64'(m_halt), 64'd0);
    end

    // Saturation and stop-on-error
    drive(4'b0, 64'b0, 4'b0, 64'b0, 1'b1, 1'b1);
    tick();
    chk("pre-sat clear", 64'({m_cnt, s_cnt, h_cnt, h_halt, h_fv}), 64'd0);
    for (int i = 1; i <= 5; i++) begin
      drive(4'b0001, pk(0, 16'h0001), 4'b0001, pk(0, 16'h0002), 1'b1, 1'b0);
      tick();
      chk($sformatf("sat%0d main cnt", i), 64'(m_cnt[7:0]), 64'(i));
      chk($sformatf("sat%0d sat cnt", i), 64'(s_cnt[1:0]), 64'((i > 3) ? 3 : i));
      chk($sformatf("sat%0d halt cnt", i), 64'(h_cnt[1:0]), 64'd1);
      chk($sformatf("sat%0d halt mis", i), 64'(h_mis), 64'((i == 1) ? 1 : 0));
      chk($sformatf("sat%0d halted", i), 64'({h_halt, s_halt}), 64'b10);
    end
    chk("halt first", 64'({h_fv, h_fch, h_fdut, h_fref}), 64'({1'b1, 2'd0, 16'h0001, 16'h0002}));
    drive(4'b0, 64'b0, 4'b0, 64'b0, 1'b1, 1'b1);
    tick();
    chk("halt clear a", 64'({h_mis, h_cnt, h_ovf, h_halt}), 64'd0);
    chk("halt clear b", 64'({h_fv, h_fch, h_fdut, h_fref}), 64'd0);
    drive(4'b0100, pk(2, 16'h0003), 4'b0100, pk(2, 16'h0004), 1'b1, 1'b0);
    tick();
    chk("rearm mis", 64'({h_mis, h_halt, h_fch}), 64'({4'b0100, 1'b1, 2'd2}));

    // Asynchronous reset mid-operation
    drive(4'b0001, pk(0, 16'h0055), 4'b0, 64'b0, 1'b1, 1'b0);
    tick();
    drive(4'b0010, pk(1, 16'h0001), 4'b0010, pk(1, 16'h0002), 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst a", 64'({m_mis, m_cnt, m_ovf}), 64'd0);
    chk("async rst b", 64'({m_fv, m_fch, m_fdut, m_fref, h_halt}), 64'd0);
    tick();
    chk("rst no result", 64'(m_mis), 64'd0);
    rst_n = 1'b1;
    drive(4'b0001, pk(0, 16'h0066), 4'b0001, pk(0, 16'h0066), 1'b1, 1'b0);
    tick();
    chk("post rst flush", 64'({m_mis, m_cnt}), 64'd0);

`ifdef NANO_LOCKSTEP_MASK_EN
    bus.i_cmp_mask = pk(0, 16'h000F);
    drive(4'b0001, pk(0, 16'h1234), 4'b0001, pk(0, 16'h1235), 1'b1, 1'b0);
    tick();
    chk("mask hides", 64'(m_mis), 64'd0);
    bus.i_cmp_mask = '0;
    tick();
    chk("mask off", 64'(m_mis), 64'b0001);
    chk("mask first", 64'({m_fdut, m_fref}), 64'({16'h1234, 16'h1235}));
`endif

    drive(4'b0, 64'b0, 4'b0, 64'b0, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
